// File: rtl/conv_pkg.sv
// Shared types for the convolution operand streamer: FSM states, beat layout,
// padding helper and the async-reset register macro used for counters.
`ifndef CONV_REG
`define CONV_REG(q, d, rv) \
  always_ff @(posedge clk or negedge arst_n_in) \
    if (!arst_n_in) q <= (rv); \
    else q <= (d);
`endif

package conv_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_e;

  localparam int unsigned CONV_DW = 16;

  typedef struct packed {
    logic               pad;
    logic [CONV_DW-1:0] act;
    logic [CONV_DW-1:0] wgt;
  } beat_t;

  function automatic int pad_of(input int k);
    return (k - 1) / 2;
  endfunction
endpackage

// File: rtl/operand_fifo.sv
// Two-entry FIFO holding returned operand pairs between the SRAM read port
// and the consumer; simultaneous push and pop are allowed.
module operand_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);
  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  `CONV_REG(mem_q, mem_d, '0)
  `CONV_REG(wr_ptr_q, wr_ptr_d, 1'b0)
  `CONV_REG(rd_ptr_q, rd_ptr_d, 1'b0)
  `CONV_REG(count_q, count_d, 2'd0)

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);
  assign count    = count_q;
endmodule

// File: rtl/conv_operand_streamer.sv
// Walks the convolution loop nest, reads activation/weight pairs from two
// synchronous SRAMs, zero-fills padding taps and streams pairs to the MAC.
module conv_operand_streamer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int KERNEL_SIZE        = 3,
  parameter int ACT_ADDR_WIDTH     = 20,
  parameter int WGT_ADDR_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      arst_n_in,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      act_re,
  output logic [ACT_ADDR_WIDTH-1:0] act_addr,
  input  logic [DATA_WIDTH-1:0]     act_rdata,
  output logic                      wgt_re,
  output logic [WGT_ADDR_WIDTH-1:0] wgt_addr,
  input  logic [DATA_WIDTH-1:0]     wgt_rdata,
  output logic                      a_valid,
  output logic                      b_valid,
  input  logic                      a_ready,
  input  logic                      b_ready,
  output logic [DATA_WIDTH-1:0]     a_data,
  output logic [DATA_WIDTH-1:0]     b_data
);
  localparam int          PAD   = pad_of(KERNEL_SIZE);
  localparam logic [63:0] W64   = 64'(FEATURE_MAP_WIDTH);
  localparam logic [63:0] CIN64 = 64'(INPUT_NB_CHANNELS);
  localparam logic [63:0] K64   = 64'(KERNEL_SIZE);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] act;
    logic [DATA_WIDTH-1:0] wgt;
  } pair_t;

  state_e      state_q, state_d;
  logic [31:0] x_q, x_d, y_q, y_d, ci_q, ci_d, co_q, co_d, kv_q, kv_d, kh_q, kh_d;
  logic        inflight_q, inflight_d, pad_rd_q, pad_rd_d, done_q, done_d;
  logic        issue, pad_tap, pop, push, fifo_full, fifo_empty;
  logic        c0, c1, c2, c3, c4, last_tap;
  logic [1:0]  fifo_count;
  logic [2:0]  committed;
  logic signed [32:0] xi, yi;
  logic [ACT_ADDR_WIDTH-1:0] act_full;
  logic [WGT_ADDR_WIDTH-1:0] wgt_full;
  pair_t       push_word, head;

  // Tap geometry and SRAM addresses for the current loop position.
  always_comb begin
    xi = $signed({1'b0, x_q}) + $signed({1'b0, kh_q}) - $signed(33'(PAD));
    yi = $signed({1'b0, y_q}) + $signed({1'b0, kv_q}) - $signed(33'(PAD));
    pad_tap = xi[32] || yi[32] || (xi[31:0] >= 32'(FEATURE_MAP_WIDTH))
              || (yi[31:0] >= 32'(FEATURE_MAP_HEIGHT));
    act_full = ACT_ADDR_WIDTH'(({{31{yi[32]}}, yi} * W64 + {{31{xi[32]}}, xi}) * CIN64
                               + {32'd0, ci_q});
    wgt_full = WGT_ADDR_WIDTH'((({32'd0, co_q} * CIN64 + {32'd0, ci_q}) * K64
                                + {32'd0, kv_q}) * K64 + {32'd0, kh_q});
  end

  // Credit: a read is only issued if its data is guaranteed a FIFO slot.
  assign pop       = a_valid & a_ready & b_ready;
  assign committed = {1'b0, fifo_count} + {2'b0, inflight_q};
  assign issue     = (state_q == STREAM) && ((committed - {2'b0, pop}) < 3'd2);

  assign c0       = (kh_q == 32'(KERNEL_SIZE - 1));
  assign c1       = c0 && (kv_q == 32'(KERNEL_SIZE - 1));
  assign c2       = c1 && (co_q == 32'(OUTPUT_NB_CHANNELS - 1));
  assign c3       = c2 && (ci_q == 32'(INPUT_NB_CHANNELS - 1));
  assign c4       = c3 && (y_q == 32'(FEATURE_MAP_HEIGHT - 1));
  assign last_tap = c4 && (x_q == 32'(FEATURE_MAP_WIDTH - 1));

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    x_d = x_q; y_d = y_q; ci_d = ci_q; co_d = co_q; kv_d = kv_q; kh_d = kh_q;
    inflight_d = issue;
    pad_rd_d   = issue & pad_tap;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          x_d = '0; y_d = '0; ci_d = '0; co_d = '0; kv_d = '0; kh_d = '0;
        end
      end
      STREAM: begin
        if (issue) begin
          kh_d = c0 ? '0 : kh_q + 32'd1;
          if (c0) kv_d = c1 ? '0 : kv_q + 32'd1;
          if (c1) co_d = c2 ? '0 : co_q + 32'd1;
          if (c2) ci_d = c3 ? '0 : ci_q + 32'd1;
          if (c3) y_d  = c4 ? '0 : y_q + 32'd1;
          if (c4) x_d  = last_tap ? '0 : x_q + 32'd1;
          if (last_tap) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave once this cycle's pop empties the FIFO with nothing in flight.
        if (!inflight_q && (fifo_count == {1'b0, pop})) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  `CONV_REG(state_q, state_d, IDLE)
  `CONV_REG(x_q, x_d, '0)
  `CONV_REG(y_q, y_d, '0)
  `CONV_REG(ci_q, ci_d, '0)
  `CONV_REG(co_q, co_d, '0)
  `CONV_REG(kv_q, kv_d, '0)
  `CONV_REG(kh_q, kh_d, '0)
  `CONV_REG(inflight_q, inflight_d, 1'b0)
  `CONV_REG(pad_rd_q, pad_rd_d, 1'b0)
  `CONV_REG(done_q, done_d, 1'b0)

  assign push          = inflight_q & ~fifo_full;
  assign push_word.act = pad_rd_q ? '0 : act_rdata;
  assign push_word.wgt = wgt_rdata;

  operand_fifo #(.WIDTH(2 * DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // a/b handshake: a pair transfers on a_valid & a_ready & b_ready; while
  // valid and not accepted, valid and data hold stable.
  assign a_valid  = ~fifo_empty;
  assign b_valid  = ~fifo_empty;
  assign a_data   = a_valid ? head.act : '0;
  assign b_data   = b_valid ? head.wgt : '0;
  assign act_re   = issue & ~pad_tap;
  assign wgt_re   = issue;
  assign act_addr = act_re ? act_full : '0;
  assign wgt_addr = wgt_re ? wgt_full : '0;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
endmodule

// File: tb/tb_conv_operand_streamer.sv
// Bench for conv_operand_streamer: a 2x2 K=3 instance and a 2x2 K=1 Cin=Cout=2
// instance, checked against a loop-nest reference model.
module tb_conv_operand_streamer;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // Instance A: W=H=2, Cin=Cout=1, K=3
  logic        start_a = 1'b0, busy_a, done_a, act_re_a, wgt_re_a;
  logic [19:0] act_addr_a;
  logic [15:0] wgt_addr_a, act_rdata_a = 16'd0, wgt_rdata_a = 16'd0;
  logic        a_valid_a, b_valid_a, rdy_a = 1'b1;
  logic [15:0] a_data_a, b_data_a;
  int          mode_a = 0;

  // Instance B: W=H=2, Cin=Cout=2, K=1
  logic        start_b = 1'b0, busy_b, done_b, act_re_b, wgt_re_b;
  logic [19:0] act_addr_b;
  logic [15:0] wgt_addr_b, act_rdata_b = 16'd0, wgt_rdata_b = 16'd0;
  logic        a_valid_b, b_valid_b, rdy_b = 1'b1;
  logic [15:0] a_data_b, b_data_b;

  conv_operand_streamer #(
    .DATA_WIDTH(16), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
    .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(3),
    .ACT_ADDR_WIDTH(20), .WGT_ADDR_WIDTH(16)
  ) dut_a (
    .clk(clk), .arst_n_in(arst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .act_re(act_re_a), .act_addr(act_addr_a), .act_rdata(act_rdata_a),
    .wgt_re(wgt_re_a), .wgt_addr(wgt_addr_a), .wgt_rdata(wgt_rdata_a),
    .a_valid(a_valid_a), .b_valid(b_valid_a), .a_ready(rdy_a), .b_ready(rdy_a),
    .a_data(a_data_a), .b_data(b_data_a)
  );

  conv_operand_streamer #(
    .DATA_WIDTH(16), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
    .INPUT_NB_CHANNELS(2), .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(1),
    .ACT_ADDR_WIDTH(20), .WGT_ADDR_WIDTH(16)
  ) dut_b (
    .clk(clk), .arst_n_in(arst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .act_re(act_re_b), .act_addr(act_addr_b), .act_rdata(act_rdata_b),
    .wgt_re(wgt_re_b), .wgt_addr(wgt_addr_b), .wgt_rdata(wgt_rdata_b),
    .a_valid(a_valid_b), .b_valid(b_valid_b), .a_ready(rdy_b), .b_ready(rdy_b),
    .a_data(a_data_b), .b_data(b_data_b)
  );

  // Synchronous-read SRAM models; activation words are never zero.
  logic [15:0] act_mem_a [256], wgt_mem_a [256], act_mem_b [256], wgt_mem_b [256];
  always @(posedge clk) begin
    if (act_re_a) act_rdata_a <= act_mem_a[act_addr_a[7:0]];
    if (wgt_re_a) wgt_rdata_a <= wgt_mem_a[wgt_addr_a[7:0]];
    if (act_re_b) act_rdata_b <= act_mem_b[act_addr_b[7:0]];
    if (wgt_re_b) wgt_rdata_b <= wgt_mem_b[wgt_addr_b[7:0]];
  end

  logic [31:0] exp_qa[$];
  logic [31:0] exp_qb[$];
  logic [19:0] exp_addr_b[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mems();
    for (int i = 0; i < 256; i++) begin
      act_mem_a[i] = 16'($urandom_range(1, 65535));
      wgt_mem_a[i] = 16'($urandom());
      act_mem_b[i] = 16'($urandom_range(1, 65535));
      wgt_mem_b[i] = 16'($urandom());
    end
  endtask

  // Reference: enumerate the loop nest and apply the padding/address rules.
  task automatic build_model(input bit sel, input int w, input int h, input int cin,
                             input int cout, input int k);
    int pad = (k - 1) / 2;
    for (int x = 0; x < w; x++)
      for (int y = 0; y < h; y++)
        for (int ci = 0; ci < cin; ci++)
          for (int co = 0; co < cout; co++)
            for (int kv = 0; kv < k; kv++)
              for (int kh = 0; kh < k; kh++) begin
                int xi, yi, aa, wa;
                bit p;
                logic [15:0] av, wv;
                xi = x + kh - pad;
                yi = y + kv - pad;
                aa = (yi * w + xi) * cin + ci;
                wa = ((co * cin + ci) * k + kv) * k + kh;
                p  = (xi < 0) || (xi >= w) || (yi < 0) || (yi >= h);
                if (sel == 1'b0) begin
                  av = p ? 16'd0 : act_mem_a[aa];
                  wv = wgt_mem_a[wa];
                  exp_qa.push_back({av, wv});
                end else begin
                  av = p ? 16'd0 : act_mem_b[aa];
                  wv = wgt_mem_b[wa];
                  exp_qb.push_back({av, wv});
                  if (!p) exp_addr_b.push_back(aa[19:0]);
                end
              end
  endtask

  // Consumer ready for instance A: 0 = always, 1 = random ~30% low, 2 = held low.
  initial forever begin
    @(posedge clk); #2;
    case (mode_a)
      0:       rdy_a = 1'b1;
      1:       rdy_a = ($urandom_range(0, 9) >= 3);
      default: rdy_a = 1'b0;
    endcase
  end

  int beats_a, zero_a, actre_a, wgtre_a, last_beat_cyc_a, done_cyc_a, start_cyc_a;
  bit done_seen_a, stall_a;
  logic [31:0] stall_data_a;

  always @(negedge clk) begin
    logic [31:0] got;
    got = {a_data_a, b_data_a};
    if (act_re_a) actre_a++;
    if (wgt_re_a) wgtre_a++;
    if (stall_a) begin
      chk("hold_valid_a", a_valid_a, 1);
      chk("hold_data_a", got, stall_data_a);
    end
    if (a_valid_a) chk("valid_pair_a", b_valid_a, 1);
    if (a_valid_a && rdy_a) begin
      chk("beat_expected_a", exp_qa.size() > 0, 1);
      if (exp_qa.size() > 0) chk("beat_a", got, exp_qa.pop_front());
      if (beats_a == 0) begin
        chk("first_act_a", a_data_a, 0);
        chk("first_wgt_a", b_data_a, wgt_mem_a[0]);
      end
      if (a_data_a == 16'd0) zero_a++;
      beats_a++;
      last_beat_cyc_a = cyc;
    end
    stall_a      = a_valid_a && !rdy_a;
    stall_data_a = got;
    if (done_a) begin
      chk("done_gap_a", cyc - last_beat_cyc_a, 1);
      chk("busy_at_done_a", busy_a, 0);
      done_seen_a = 1'b1;
      done_cyc_a  = cyc;
    end
  end

  int beats_b, zero_b, actre_b;
  bit done_seen_b;
  always @(negedge clk) begin
    if (act_re_b) begin
      actre_b++;
      chk("addr_expected_b", exp_addr_b.size() > 0, 1);
      if (exp_addr_b.size() > 0) chk("act_addr_b", act_addr_b, exp_addr_b.pop_front());
    end
    if (a_valid_b && rdy_b) begin
      chk("beat_expected_b", exp_qb.size() > 0, 1);
      if (exp_qb.size() > 0) chk("beat_b", {a_data_b, b_data_b}, exp_qb.pop_front());
      if (a_data_b == 16'd0) zero_b++;
      beats_b++;
    end
    if (done_b) done_seen_b = 1'b1;
  end

  task automatic prep_a();
    beats_a = 0; zero_a = 0; actre_a = 0; wgtre_a = 0;
    done_seen_a = 1'b0; stall_a = 1'b0; last_beat_cyc_a = 0;
    exp_qa.delete();
    fill_mems();
    build_model(1'b0, 2, 2, 1, 1, 3);
  endtask

  task automatic start_layer_a();
    @(posedge clk); #1;
    start_a = 1'b1;
    start_cyc_a = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (!done_seen_a && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout_a", done_seen_a, 1);
  endtask

  initial begin
    int n;
    int rel_cyc;
    fill_mems();
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_re", {act_re_a, wgt_re_a}, 0);
    chk("rst_addr", {act_addr_a, wgt_addr_a}, 0);
    chk("rst_valid", {a_valid_a, b_valid_a}, 0);
    chk("rst_data", {a_data_a, b_data_a}, 0);
    repeat (3) @(posedge clk);
    #2 arst_n = 1'b1;

    // Full layer with ready held high.
    mode_a = 0;
    prep_a();
    start_layer_a();
    wait_done_a(2000);
    chk("beats_ready1", beats_a, 36);
    chk("pad_beats", zero_a, 20);
    chk("act_re_pulses", actre_a, 16);
    chk("wgt_re_pulses", wgtre_a, 36);
    chk("left_over_ready1", exp_qa.size(), 0);
    chk("latency_to_done", done_cyc_a - start_cyc_a, 39);

    // K=1 instance: no pad taps, address order follows the loop nest.
    beats_b = 0; zero_b = 0; actre_b = 0; done_seen_b = 1'b0;
    exp_qb.delete(); exp_addr_b.delete();
    build_model(1'b1, 2, 2, 2, 2, 1);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while (!done_seen_b && n < 2000) begin @(posedge clk); #1; n++; end
    chk("done_timeout_b", done_seen_b, 1);
    chk("beats_b", beats_b, 16);
    chk("pad_beats_b", zero_b, 0);
    chk("act_re_pulses_b", actre_b, 16);
    chk("left_over_b", exp_qb.size() + exp_addr_b.size(), 0);

    // Random back-pressure.
    mode_a = 1;
    prep_a();
    start_layer_a();
    wait_done_a(4000);
    chk("beats_random", beats_a, 36);
    chk("left_over_random", exp_qa.size(), 0);

    // Second start during STREAM is ignored.
    mode_a = 0;
    prep_a();
    start_layer_a();
    repeat (5) @(posedge clk);
    #1 start_a = 1'b1;
    chk("busy_mid_layer", busy_a, 1);
    @(posedge clk); #1 start_a = 1'b0;
    wait_done_a(2000);
    chk("beats_restart_pulse", beats_a, 36);
    chk("left_over_restart_pulse", exp_qa.size(), 0);
    repeat (5) @(posedge clk);
    #1 chk("idle_after_ignored_start", busy_a, 0);

    // Reset after beat 10, then a clean full layer.
    prep_a();
    start_layer_a();
    n = 0;
    while (beats_a < 10 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("reached_beat10", beats_a, 10);
    #1 arst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_re", {act_re_a, wgt_re_a}, 0);
    chk("mid_rst_addr", {act_addr_a, wgt_addr_a}, 0);
    chk("mid_rst_valid", {a_valid_a, b_valid_a}, 0);
    chk("mid_rst_data", {a_data_a, b_data_a}, 0);
    @(posedge clk); #2 arst_n = 1'b1;
    prep_a();
    start_layer_a();
    wait_done_a(2000);
    chk("beats_after_reset", beats_a, 36);
    chk("left_over_after_reset", exp_qa.size(), 0);

    // Ready low for 20 cycles from the first valid.
    mode_a = 2;
    prep_a();
    start_layer_a();
    n = 0;
    while (!a_valid_a && n < 100) begin @(posedge clk); #1; n++; end
    chk("first_valid_seen", a_valid_a, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("reads_before_release", wgtre_a, 2);
    chk("act_reads_before_release", actre_a, 0);
    chk("no_beats_while_stalled", beats_a, 0);
    chk("valid_while_stalled", a_valid_a, 1);
    mode_a = 0;
    rel_cyc = cyc;
    wait_done_a(2000);
    chk("beats_after_stall", beats_a, 36);
    chk("release_to_done", done_cyc_a - rel_cyc, 36);
    chk("left_over_stall", exp_qa.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
